// File: rtl/tlc_pkg.sv
// Shared types for the two-road traffic-light controller: state encoding and light codes.
// Pure declarations; no latency or flow control of its own.
package tlc_pkg;

    typedef enum logic [2:0] {
        GREEN_A  = 3'd0,
        YELLOW_A = 3'd1,
        ALLRED_A = 3'd2,
        GREEN_B  = 3'd3,
        YELLOW_B = 3'd4,
        ALLRED_B = 3'd5
    } tlc_state_t;

    // {red,yellow,green}, one-hot
    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/traffic_light_fsm_if.sv
// Traffic-light controller bus: slow tick and sensors in, two light buses out (debug taps with TLC_DEBUG_EN).
// Combinational wiring only; no latency, no backpressure.
interface traffic_light_fsm_if;
    logic       slow_clk;
    logic       sensor_a;
    logic       sensor_b;
    logic [2:0] light_a;
    logic [2:0] light_b;
`ifdef TLC_DEBUG_EN
    logic [2:0] state_dbg;
    logic       step_dbg;
`endif

    modport master (
        output slow_clk, sensor_a, sensor_b,
`ifdef TLC_DEBUG_EN
        input  state_dbg, step_dbg,
`endif
        input  light_a, light_b
    );

    modport slave (
        input  slow_clk, sensor_a, sensor_b,
`ifdef TLC_DEBUG_EN
        output state_dbg, step_dbg,
`endif
        output light_a, light_b
    );
endinterface

// File: rtl/traffic_light_fsm_tick_sync.sv
// 2-flop synchroniser plus rising-edge detector; o_step is a registered one-clk pulse per rise.
// Latency: input first sampled high at edge N -> o_step high after edge N+2; no backpressure.
module tick_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_step
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
            r_step   <= 1'b0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_step   <= r_sync & ~r_sync_d;
        end
    end

    assign o_step = r_step;

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road light FSM advanced only by rising edges of slow_clk (treated as data); lights change 3 edges after a rise.
// No backpressure; TLC_DEBUG_EN adds state_dbg/step_dbg on the interface.
module traffic_light_fsm
    import tlc_pkg::*;
#(
    parameter int GREEN_MIN_STEPS = 2,
    parameter int YELLOW_STEPS    = 1,
    parameter int ALLRED_STEPS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    traffic_light_fsm_if.slave tlc
);

    localparam int DW = $clog2(max3(GREEN_MIN_STEPS, YELLOW_STEPS, ALLRED_STEPS)) + 1;

    localparam logic [DW-1:0] GRN_LAST = DW'(GREEN_MIN_STEPS - 1);
    localparam logic [DW-1:0] YEL_LAST = DW'(YELLOW_STEPS - 1);
    localparam logic [DW-1:0] RED_LAST = DW'(ALLRED_STEPS - 1);

    logic          w_step;
    logic          r_sa_meta, r_sa;
    logic          r_sb_meta, r_sb;
    tlc_state_t    r_state, w_state_nxt;
    logic [DW-1:0] r_dwell, w_dwell_nxt;
    logic [2:0]    r_light_a, r_light_b;
    logic [2:0]    w_light_a, w_light_b;

    tick_sync u_tick_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (tlc.slow_clk),
        .o_step  (w_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sa_meta <= 1'b0;
            r_sa      <= 1'b0;
            r_sb_meta <= 1'b0;
            r_sb      <= 1'b0;
        end else begin
            r_sa_meta <= tlc.sensor_a;
            r_sa      <= r_sa_meta;
            r_sb_meta <= tlc.sensor_b;
            r_sb      <= r_sb_meta;
        end
    end

    // Green holds while its own road has traffic; dwell saturates at GRN_LAST meanwhile.
    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        case (r_state)
            GREEN_A: if (w_step) begin
                if (r_dwell < GRN_LAST)  w_dwell_nxt = r_dwell + DW'(1);
                else if (!r_sa)          begin w_state_nxt = YELLOW_A; w_dwell_nxt = '0; end
            end
            YELLOW_A: if (w_step) begin
                if (r_dwell == YEL_LAST) begin w_state_nxt = ALLRED_A; w_dwell_nxt = '0; end
                else                     w_dwell_nxt = r_dwell + DW'(1);
            end
            ALLRED_A: if (w_step) begin
                if (r_dwell == RED_LAST) begin w_state_nxt = GREEN_B; w_dwell_nxt = '0; end
                else                     w_dwell_nxt = r_dwell + DW'(1);
            end
            GREEN_B: if (w_step) begin
                if (r_dwell < GRN_LAST)  w_dwell_nxt = r_dwell + DW'(1);
                else if (!r_sb)          begin w_state_nxt = YELLOW_B; w_dwell_nxt = '0; end
            end
            YELLOW_B: if (w_step) begin
                if (r_dwell == YEL_LAST) begin w_state_nxt = ALLRED_B; w_dwell_nxt = '0; end
                else                     w_dwell_nxt = r_dwell + DW'(1);
            end
            ALLRED_B: if (w_step) begin
                if (r_dwell == RED_LAST) begin w_state_nxt = GREEN_A; w_dwell_nxt = '0; end
                else                     w_dwell_nxt = r_dwell + DW'(1);
            end
            default: begin
                w_state_nxt = ALLRED_B;
                w_dwell_nxt = '0;
            end
        endcase
    end

    // Lights decode from the next state so they register on the same edge as the state.
    always_comb begin
        w_light_a = LIGHT_RED;
        w_light_b = LIGHT_RED;
        case (w_state_nxt)
            GREEN_A:  w_light_a = LIGHT_GRN;
            YELLOW_A: w_light_a = LIGHT_YEL;
            GREEN_B:  w_light_b = LIGHT_GRN;
            YELLOW_B: w_light_b = LIGHT_YEL;
            default: begin
                w_light_a = LIGHT_RED;
                w_light_b = LIGHT_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= GREEN_A;
            r_dwell   <= '0;
            r_light_a <= LIGHT_GRN;
            r_light_b <= LIGHT_RED;
        end else begin
            r_state   <= w_state_nxt;
            r_dwell   <= w_dwell_nxt;
            r_light_a <= w_light_a;
            r_light_b <= w_light_b;
        end
    end

    assign tlc.light_a = r_light_a;
    assign tlc.light_b = r_light_b;

`ifdef TLC_DEBUG_EN
    assign tlc.state_dbg = r_state;
    assign tlc.step_dbg  = w_step;
`endif

endmodule
